// File: rtl/rfsoc_gpio_cfg_deser.sv
// GPIO serial configuration deserializer: synchronizes the PS gpio_ctrl bus into pl_clk, shifts serial words into
// shadow registers and commits each completed word atomically. Optional macro: RFSOC_CFG_GLITCH_FILTER_EN.
package rfsoc_config;
  localparam int SDATA                = 0;
  localparam int TRIGGER_LINE         = 1;
  localparam int CHANNEL_SEL_CLK      = 2;
  localparam int CYCLE_COUNT_CLK      = 3;
  localparam int MASK_CLK             = 4;
  localparam int LOCKING_WAVEFORM_CLK = 5;
  localparam int PRE_DELAY_CYCLE_CLK  = 6;
  localparam int POST_DELAY_CYCLE_CLK = 7;
  localparam int MUX_SET_CLK          = 8;
  localparam int MASK_ENABLE_CLK      = 9;
endpackage

// One serial register: shadow shift, wrap counter, atomic commit with one-cycle strobe.
module rfsoc_cfg_shift_lane #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift,
  input  logic         sdata,
  output logic [N-1:0] cfg,
  output logic         update
);
  localparam int CW = $clog2(N);

  logic [N-1:0]  shadow;
  logic [N-1:0]  next_word;
  logic [CW-1:0] cnt;

  // LSB-first: first bit sent ends up in bit 0 after N shifts
  assign next_word = {sdata, shadow[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
      cfg    <= '0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (shift) begin
        shadow <= next_word;
        cnt    <= cnt + CW'(1);
        if (cnt == CW'(N-1)) begin
          cfg    <= next_word;
          update <= 1'b1;
        end
      end
    end
  end
endmodule

module rfsoc_gpio_cfg_deser
  import rfsoc_config::*;
#(
  parameter int WIDE_W = 256,
  parameter int CH_W   = 16,
  parameter int FLAG_W = 8
) (
  input  logic              pl_clk,
  input  logic              rst,
  input  logic [15:0]       gpio_ctrl,
  output logic [CH_W-1:0]   cfg_channel_sel,
  output logic              cfg_mux_sel,
  output logic              cfg_mask_enable,
  output logic [WIDE_W-1:0] cfg_cycle_count,
  output logic [WIDE_W-1:0] cfg_mask,
  output logic [WIDE_W-1:0] cfg_locking_wave,
  output logic [WIDE_W-1:0] cfg_pre_delay,
  output logic [WIDE_W-1:0] cfg_post_delay,
  output logic [7:0]        cfg_update,
  output logic              trigger_pulse
);
`ifdef RFSOC_CFG_GLITCH_FILTER_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  localparam int NUM_WIDE = 5;
  localparam int WIDE_CLK [NUM_WIDE] = '{CYCLE_COUNT_CLK, MASK_CLK, LOCKING_WAVEFORM_CLK,
                                        PRE_DELAY_CYCLE_CLK, POST_DELAY_CYCLE_CLK};

  // [0],[1]: 2-flop synchronizer; [2]: history; [3]: second history for the glitch filter
  logic [STAGES-1:0][15:0] sync_pipe;
  logic [15:0]             rise;
  logic                    sdata_al;
  logic [15:0]             edge_q;
  logic                    sdata_q;

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[STAGES-2:0], gpio_ctrl};
  end

`ifdef RFSOC_CFG_GLITCH_FILTER_EN
  // low, then two consecutive highs; sdata taken one stage later to stay aligned
  assign rise     = sync_pipe[1] & sync_pipe[2] & ~sync_pipe[3];
  assign sdata_al = sync_pipe[2][SDATA];
`else
  assign rise     = sync_pipe[1] & ~sync_pipe[2];
  assign sdata_al = sync_pipe[1][SDATA];
`endif

  always_ff @(posedge pl_clk or posedge rst) begin
    if (rst) begin
      edge_q        <= '0;
      sdata_q       <= 1'b0;
      trigger_pulse <= 1'b0;
    end else begin
      edge_q        <= rise;
      sdata_q       <= sdata_al;
      trigger_pulse <= edge_q[TRIGGER_LINE];
    end
  end

  logic [NUM_WIDE-1:0][WIDE_W-1:0] wide_cfg;
  logic [NUM_WIDE-1:0]             wide_upd;

  generate
    for (genvar g = 0; g < NUM_WIDE; g++) begin : g_wide
      rfsoc_cfg_shift_lane #(.N(WIDE_W)) u_lane (
        .clk    (pl_clk),
        .rst    (rst),
        .shift  (edge_q[WIDE_CLK[g]]),
        .sdata  (sdata_q),
        .cfg    (wide_cfg[g]),
        .update (wide_upd[g])
      );
    end
  endgenerate

  logic              ch_upd, mux_upd, me_upd;
  logic [FLAG_W-1:0] mux_word, me_word;

  rfsoc_cfg_shift_lane #(.N(CH_W)) u_chan (
    .clk    (pl_clk),
    .rst    (rst),
    .shift  (edge_q[CHANNEL_SEL_CLK]),
    .sdata  (sdata_q),
    .cfg    (cfg_channel_sel),
    .update (ch_upd)
  );

  rfsoc_cfg_shift_lane #(.N(FLAG_W)) u_mux (
    .clk    (pl_clk),
    .rst    (rst),
    .shift  (edge_q[MUX_SET_CLK]),
    .sdata  (sdata_q),
    .cfg    (mux_word),
    .update (mux_upd)
  );

  rfsoc_cfg_shift_lane #(.N(FLAG_W)) u_mask_en (
    .clk    (pl_clk),
    .rst    (rst),
    .shift  (edge_q[MASK_ENABLE_CLK]),
    .sdata  (sdata_q),
    .cfg    (me_word),
    .update (me_upd)
  );

  // flags are sent as 8 identical bits; bit 0 is authoritative
  assign cfg_mux_sel      = mux_word[0];
  assign cfg_mask_enable  = me_word[0];
  assign cfg_cycle_count  = wide_cfg[0];
  assign cfg_mask         = wide_cfg[1];
  assign cfg_locking_wave = wide_cfg[2];
  assign cfg_pre_delay    = wide_cfg[3];
  assign cfg_post_delay   = wide_cfg[4];
  assign cfg_update       = {me_upd, mux_upd, wide_upd, ch_upd};
endmodule

// File: tb/tb_rfsoc_gpio_cfg_deser.sv
// Scoreboard bench for rfsoc_gpio_cfg_deser: bit-accumulating reference model feeds an expected-commit queue.
module tb_rfsoc_gpio_cfg_deser;
  import rfsoc_config::*;

  logic         pl_clk = 1'b0;
  logic         rst;
  logic [15:0]  gpio_ctrl;
  logic [15:0]  cfg_channel_sel;
  logic         cfg_mux_sel, cfg_mask_enable, trigger_pulse;
  logic [255:0] cfg_cycle_count, cfg_mask, cfg_locking_wave, cfg_pre_delay, cfg_post_delay;
  logic [7:0]   cfg_update;

  rfsoc_gpio_cfg_deser dut (
    .pl_clk           (pl_clk),
    .rst              (rst),
    .gpio_ctrl        (gpio_ctrl),
    .cfg_channel_sel  (cfg_channel_sel),
    .cfg_mux_sel      (cfg_mux_sel),
    .cfg_mask_enable  (cfg_mask_enable),
    .cfg_cycle_count  (cfg_cycle_count),
    .cfg_mask         (cfg_mask),
    .cfg_locking_wave (cfg_locking_wave),
    .cfg_pre_delay    (cfg_pre_delay),
    .cfg_post_delay   (cfg_post_delay),
    .cfg_update       (cfg_update),
    .trigger_pulse    (trigger_pulse)
  );

  always #5 pl_clk = ~pl_clk;

`ifdef RFSOC_CFG_GLITCH_FILTER_EN
  localparam int TRIG_HI = 2;
`else
  localparam int TRIG_HI = 1;
`endif

  localparam int CLK_BIT [8] = '{CHANNEL_SEL_CLK, CYCLE_COUNT_CLK, MASK_CLK, LOCKING_WAVEFORM_CLK,
                                 PRE_DELAY_CYCLE_CLK, POST_DELAY_CYCLE_CLK, MUX_SET_CLK, MASK_ENABLE_CLK};
  localparam int LEN [8]     = '{16, 256, 256, 256, 256, 256, 8, 8};

  typedef struct {
    int           id;
    logic [255:0] val;
  } exp_t;

  exp_t         exp_q[$];
  logic [255:0] acc [8];
  int           cnt [8];
  logic [255:0] prev [8];
  int           checks = 0, errors = 0;
  int           exp_trig = 0, got_trig = 0;
  logic         trig_prev = 1'b0;

  // reference: bit k of a word is the k-th bit sent; a full word becomes one expected commit
  function automatic void model_shift(int id, logic b);
    exp_t e;
    acc[id][cnt[id]] = b;
    cnt[id]++;
    if (cnt[id] == LEN[id]) begin
      e.id  = id;
      e.val = acc[id];
      exp_q.push_back(e);
      acc[id] = '0;
      cnt[id] = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      acc[i] = '0;
      cnt[i] = 0;
    end
  endfunction

  function automatic logic [255:0] out_val(int i);
    case (i)
      0:       return 256'(cfg_channel_sel);
      1:       return cfg_cycle_count;
      2:       return cfg_mask;
      3:       return cfg_locking_wave;
      4:       return cfg_pre_delay;
      5:       return cfg_post_delay;
      6:       return 256'(cfg_mux_sel);
      default: return 256'(cfg_mask_enable);
    endcase
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge pl_clk);
    #1;
  endtask

  // one serial bit on every clock in sel; optional trigger edge coincident with the clocks
  task automatic send(logic [7:0] sel, logic b, logic trig);
    gpio_ctrl[SDATA] = b;
    cyc(3);
    for (int i = 0; i < 8; i++)
      if (sel[i]) begin
        gpio_ctrl[CLK_BIT[i]] = 1'b1;
        model_shift(i, b);
      end
    if (trig) begin
      gpio_ctrl[TRIGGER_LINE] = 1'b1;
      exp_trig++;
    end
    cyc(3);
    for (int i = 0; i < 8; i++) gpio_ctrl[CLK_BIT[i]] = 1'b0;
    gpio_ctrl[TRIGGER_LINE] = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gpio_ctrl = '0;
    model_reset();
    cyc(3);
    rst = 1'b0;
    cyc(2);
  endtask

  // monitor: each strobe pops the oldest expected word for that register; outputs may only move with a strobe
  always @(negedge pl_clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) prev[i] = '0;
      trig_prev = 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [255:0] cur, req;
        int idx;
        cur = out_val(i);
        if (cfg_update[i]) begin
          idx = -1;
          for (int k = 0; k < exp_q.size(); k++)
            if (idx < 0 && exp_q[k].id == i) idx = k;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_update reg %0d: got value %h, required no strobe", i, cur);
          end else begin
            req = (i >= 6) ? 256'(exp_q[idx].val[0]) : exp_q[idx].val;
            if (cur !== req) begin
              errors++;
              $display("FAIL commit reg %0d: got %h required %h", i, cur, req);
            end
            exp_q.delete(idx);
          end
        end else if (cur !== prev[i]) begin
          checks++;
          errors++;
          $display("FAIL partial_word reg %0d: got %h required %h", i, cur, prev[i]);
        end
        prev[i] = cur;
      end
      if (trigger_pulse) begin
        got_trig++;
        if (trig_prev) begin
          checks++;
          errors++;
          $display("FAIL trigger_width: got 2+ cycles high, required 1");
        end
      end
      trig_prev = trigger_pulse;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] mv, ten;
    model_reset();
    do_reset();

    check("reset_channel_sel", 256'(cfg_channel_sel), '0);
    check("reset_cycle_count", cfg_cycle_count, '0);
    check("reset_mask", cfg_mask, '0);
    check("reset_flags", 256'({cfg_mux_sel, cfg_mask_enable}), '0);
    check("reset_update", 256'(cfg_update), '0);
    check("reset_trigger", 256'(trigger_pulse), '0);

    // channel select ch=5
    for (int i = 0; i < 15; i++) send(8'h01, (i == 5), 1'b0);
    check("chan_before_last", 256'(cfg_channel_sel), '0);
    send(8'h01, 1'b0, 1'b0);
    check("chan_sel_5", 256'(cfg_channel_sel), 256'h0020);

    // wide mask: upper half zero, lower half ones
    mv = {{8{16'h0000}}, {8{16'hFFFF}}};
    for (int i = 0; i < 256; i++) send(8'h04, mv[i], 1'b0);
    check("mask_value", cfg_mask, mv);

    // mux flag set then clear
    for (int i = 0; i < 8; i++) send(8'h40, 1'b1, 1'b0);
    check("mux_set", 256'(cfg_mux_sel), 256'd1);
    for (int i = 0; i < 8; i++) send(8'h40, 1'b0, 1'b0);
    check("mux_clear", 256'(cfg_mux_sel), 256'd0);

    // random mixed traffic: simultaneous clocks and coincident triggers
    for (int n = 0; n < 400; n++) begin
      logic [7:0] sel;
      for (int i = 0; i < 8; i++) sel[i] = ($urandom_range(0, 3) != 0);
      send(sel, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    // reset mid-load, then a fresh load of 10
    for (int i = 0; i < 100; i++) send(8'h02, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();
    check("midload_reset_cycle_count", cfg_cycle_count, '0);
    ten = 256'd10;
    for (int i = 0; i < 256; i++) send(8'h02, ten[i], 1'b0);
    check("cycle_count_10", cfg_cycle_count, ten);

    // trigger: short pulses, then a long level
    for (int n = 0; n < 20; n++) begin
      gpio_ctrl[TRIGGER_LINE] = 1'b1;
      cyc(TRIG_HI);
      gpio_ctrl[TRIGGER_LINE] = 1'b0;
      exp_trig++;
      cyc(50);
    end
    gpio_ctrl[TRIGGER_LINE] = 1'b1;
    exp_trig++;
    cyc(100);
    gpio_ctrl[TRIGGER_LINE] = 1'b0;
    cyc(10);
    check("trigger_count", 256'(got_trig), 256'(exp_trig));

    // one-cycle mask_clk glitch with sdata=1, then complete the word
    gpio_ctrl[SDATA] = 1'b1;
    cyc(4);
    gpio_ctrl[MASK_CLK] = 1'b1;
    cyc(1);
    gpio_ctrl[MASK_CLK] = 1'b0;
`ifndef RFSOC_CFG_GLITCH_FILTER_EN
    model_shift(2, 1'b1);
`endif
    cyc(4);
    send(8'h04, 1'b0, 1'b0);
    while (cnt[2] != 0) send(8'h04, 1'b0, 1'b0);
    cyc(10);

    check("scoreboard_drained", 256'(exp_q.size()), '0);
    check("trigger_total", 256'(got_trig), 256'(exp_trig));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rfsoc_gpio_cfg_deser.md
# rfsoc_gpio_cfg_deser

GPIO serial configuration deserializer for the RFSoC PL controller. Sits between the PS-driven 16-bit `gpio_ctrl` bus and the per-channel waveform/playback stages. It synchronizes the GPIO lines into `pl_clk` and detects serial-clock rising edges. It shifts `sdata` into shadow registers and commits each completed word atomically, with a one-cycle update strobe. It also converts the trigger line into a single-cycle pulse.

## Interface
Parameters:
- `WIDE_W`, 256: length of the wide serial registers (cycle count, mask, locking waveform, pre/post delay).
- `CH_W`, 16: channel-select length.
- `FLAG_W`, 8: shift count for the mux-select and mask-enable flags.
- GPIO bit indices are taken from the `rfsoc_config` package constants: `sdata`, `trigger_line`, `channel_sel_clk`, `cycle_count_clk`, `mask_clk`, `locking_waveform_clk`, `pre_delay_cycle_clk`, `post_delay_cycle_clk`, `mux_set_clk`, `mask_enable_clk`.

Ports:
- `pl_clk` in 1: the only clock.
- `rst` in 1: asynchronous reset, active-high.
- `gpio_ctrl` in 16: asynchronous PS GPIO bus.
- `cfg_channel_sel` out 16: one-hot channel select.
- `cfg_mux_sel` out 1: loop-back mux select.
- `cfg_mask_enable` out 1: mask enable.
- `cfg_cycle_count`, `cfg_mask`, `cfg_locking_wave`, `cfg_pre_delay`, `cfg_post_delay` out `WIDE_W` each: committed wide values.
- `cfg_update` out 8: one-cycle commit strobes. Bit assignment: 0 chan, 1 cycle, 2 mask, 3 lock, 4 pre, 5 post, 6 mux, 7 mask_en.
- `trigger_pulse` out 1: one-cycle pulse per trigger-line rising edge.

## Operation
- **Synchronizer:** every `gpio_ctrl` bit passes through a 2-flop synchronizer, then a history flop. A rising edge is `sync & ~hist`.
- **Shift rule:** on a rising edge of serial clock X, shadow_X <= {sdata_sync, shadow_X[N-1:1]}, with the LSB sent first. After N shifts, the first bit sent lands in bit 0.
- **Counters:** each register has its own shift counter, widths 8/4/3 bits for N = 256/16/8. Counters wrap naturally.
- **Commit:** the edge that brings a counter back to 0 (the Nth shift) copies the full shadow, including the new bit, into the `cfg_*` output. It also pulses the matching `cfg_update` bit for one cycle.
- **Outputs between commits:** `cfg_*` outputs never show partial words.
- **Channel select:** 16 shifts of the pattern `(i == ch)`, i = 0..15, yields `cfg_channel_sel` = 1 << ch.
- **Flags:** `cfg_mux_sel` and `cfg_mask_enable` take bit 0 of their committed 8-bit shadow. The PS sends the same value 8 times.
- **Trigger:** a synchronized rising edge of `trigger_line` gives `trigger_pulse` high for exactly one cycle. A level held high gives no further pulses.
- **Simultaneous edges:**
  - Two or more serial clocks rising in the same cycle each shift the same `sdata` bit independently.
  - A trigger edge coincident with a commit produces both outputs in that cycle.
- **Reset (asynchronous, including mid-load):** clears all synchronizers, shadows, counters and outputs. A partial load is discarded, and the next load starts at count 0.
- **Reset values:** all outputs reset to 0: `cfg_*` 0, `cfg_update` 0, `trigger_pulse` 0.

## Timing
- **Latency:** a `gpio_ctrl` change that is stable before `pl_clk` edge n is seen by the edge detect after edge n+2. The shadow or commit update happens at edge n+3. `cfg_update` and `trigger_pulse` are high from after edge n+3 until after edge n+4.
- **Data alignment:** `sdata` and the serial clocks use identical synchronizer depth, so they stay aligned.
- **PS setup/hold:** the PS must hold `sdata` stable for ≥3 `pl_clk` cycles before and after each serial-clock rise.
- **Minimum high/low:** each serial-clock high and low phase is ≥2 `pl_clk` cycles.
- **Throughput:** at most one shift per register per 4 `pl_clk` cycles.

## Configuration
- **Macro:** `RFSOC_CFG_GLITCH_FILTER_EN`.
- **Defined:** a serial-clock or trigger rising edge is accepted only when the synchronized line has been low for ≥1 cycle and is then high for 2 consecutive cycles. A one-cycle high glitch is ignored. All latencies in Timing grow by 1 cycle.
- **Undefined:** a single-sample edge detect with the latencies stated in Timing.

## Test plan
- **Channel select:** shift the channel-select pattern for ch=5 → after the 16th edge, `cfg_channel_sel`=16'h0020 and `cfg_update[0]` pulses once. The output stays 0 through the first 15 edges.
- **Wide register:** shift `cfg_mask` = {8{16'h0000}, 8{16'hFFFF}} → exact value after 256 edges, exactly one `cfg_update[2]` pulse, and no partial value visible at edges 1..255.
- **Flag:** `mux_set_clk` ×8 with `sdata`=1 → `cfg_mux_sel`=1. Then ×8 with `sdata`=0 → `cfg_mux_sel`=0.
- **Trigger:** hold `trigger_line` high for 1 ps cycle, 20 times with 50-cycle gaps → exactly 20 single-cycle `trigger_pulse`s. A 100-cycle high level gives one pulse.
- **Reset mid-load:** assert `rst` after 100 `cycle_count_clk` edges, then load 10 → `cfg_cycle_count`=10 after 256 further edges.
- **Glitch filter:** with the macro defined, a 1-cycle `mask_clk` glitch → no shift. Without the macro → one shift.
